// File: rtl/product_accumulator.sv
// product_accumulator
// Accumulate half of a multiply-accumulate path. It sums LEN consecutive
// unsigned products into a saturating accumulator and then offers the block
// sum, with a sticky overflow flag, over a valid/ready handshake. While a
// finished result waits for the consumer, no new products are accepted.

module product_accumulator #(
    parameter int P_W   = 8,   // product width
    parameter int ACC_W = 16,  // accumulator / sum width, must be >= P_W
    parameter int LEN   = 4    // products per block, must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [P_W-1:0]   in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    // Reject parameter sets the datapath cannot represent.
    generate
        if (ACC_W < P_W) begin : g_bad_acc_w
            $error("product_accumulator: ACC_W must be >= P_W");
        end
        if (LEN < 1) begin : g_bad_len
            $error("product_accumulator: LEN must be >= 1");
        end
    endgenerate

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    // Two-state controller: collecting products, or holding a finished result.
    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_DONE  = 1'b1;

    logic             r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_sum;
    logic             r_out_ovf;

    logic [ACC_W:0]   w_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_sat;

    // The extra top bit of the adder is the overflow carry; on carry the
    // result clamps to all ones. Once clamped, adding any product (even zero)
    // keeps it at all ones, so saturation persists for the rest of the block.
    assign w_ext   = {{(ACC_W + 1 - P_W){1'b0}}, in_data};
    assign w_sum   = {1'b0, r_acc} + w_ext;
    assign w_carry = w_sum[ACC_W];
    assign w_sat   = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_sum;
    assign out_ovf   = r_out_ovf;

    // Block accumulation, result capture and handoff.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update
        // in this block sees the pre-edge values of the others.
        if (rst) begin
            r_state   <= ST_ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_sum     <= '0;
            r_out_ovf <= 1'b0;
        end else if (r_state == ST_ACCUM) begin
            // in_ready is high here, so in_valid alone means a transfer.
            if (in_valid) begin
                r_acc <= w_sat;
                r_ovf <= r_ovf | w_carry;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    r_state   <= ST_DONE;
                    r_sum     <= w_sat;
                    r_out_ovf <= r_ovf | w_carry;
                end
            end
        end else begin
            // Result held stable; in_valid ignored until the consumer takes it.
            if (out_ready) begin
                r_state <= ST_ACCUM;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: a table of directed vectors, hand-written
// stall / reset / LEN=1 sequences, then randomized traffic against a
// block-level arithmetic model.

module tb_product_accumulator;

    localparam int MAX9 = 511;

    logic       clk = 1'b0;
    logic       rst;

    // Main instance: P_W=8, ACC_W=9, LEN=4
    logic       iv, ordy, ir, ov, oovf;
    logic [7:0] din;
    logic [8:0] osum;

    // Second instance: P_W=8, ACC_W=8, LEN=1
    logic       iv1, ordy1, ir1, ov1, oovf1;
    logic [7:0] din1;
    logic [7:0] osum1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    product_accumulator #(.P_W(8), .ACC_W(9), .LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv),
        .in_data   (din),
        .in_ready  (ir),
        .out_valid (ov),
        .out_ready (ordy),
        .out_sum   (osum),
        .out_ovf   (oovf)
    );

    product_accumulator #(.P_W(8), .ACC_W(8), .LEN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv1),
        .in_data   (din1),
        .in_ready  (ir1),
        .out_valid (ov1),
        .out_ready (ordy1),
        .out_sum   (osum1),
        .out_ovf   (oovf1)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [8:0] sum;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic e_ir, input logic e_ov,
                              input logic [8:0] e_sum, input logic e_ovf);
        check({tag, ".in_ready"},  32'(ir),   32'(e_ir));
        check({tag, ".out_valid"}, 32'(ov),   32'(e_ov));
        check({tag, ".out_sum"},   32'(osum), 32'(e_sum));
        check({tag, ".out_ovf"},   32'(oovf), 32'(e_ovf));
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        iv   = v;
        din  = d;
        ordy = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    // Feed four accepted products into the main instance (it must be in ACCUM).
    task automatic feed4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        logic [7:0] vals [4];
        vals = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, vals[k], 1'b0);
            tick();
        end
        drive(1'b0, 8'd0, 1'b0);
    endtask

    // Block-level reference state for the randomized phase.
    int   m_blk_sum;
    int   m_blk_cnt;
    bit   m_pend;
    int   m_last_sum;
    bit   m_last_ovf;

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
        iv1 = 1'b0; din1 = 8'd0; ordy1 = 1'b0;
        tick();
        tick();

        // Reset state of both instances.
        check_main("reset", 1'b1, 1'b0, 9'd0, 1'b0);
        check("reset1.in_ready",  32'(ir1),   32'd1);
        check("reset1.out_valid", 32'(ov1),   32'd0);
        check("reset1.out_sum",   32'(osum1), 32'd0);
        rst = 1'b0;

        // Directed table: back-to-back block, saturation and flag clearing,
        // bubbles. Each row: inputs, then expected outputs after the edge.
        tbl = {};
        // Stream 15 x4: result 60 the cycle after the 4th accept.
        tbl.push_back('{1'b1, 8'd15,  1'b1, 1'b1, 1'b0, 9'd60 - 9'd60, 1'b0});
        tbl.push_back('{1'b1, 8'd15,  1'b1, 1'b1, 1'b0, 9'd0,   1'b0});
        tbl.push_back('{1'b1, 8'd15,  1'b1, 1'b1, 1'b0, 9'd0,   1'b0});
        tbl.push_back('{1'b1, 8'd15,  1'b1, 1'b0, 1'b1, 9'd60,  1'b0});
        tbl.push_back('{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 9'd60,  1'b0});
        // Stream 255 x4: saturates, overflow flagged.
        tbl.push_back('{1'b1, 8'd255, 1'b1, 1'b1, 1'b0, 9'd60,  1'b0});
        tbl.push_back('{1'b1, 8'd255, 1'b1, 1'b1, 1'b0, 9'd60,  1'b0});
        tbl.push_back('{1'b1, 8'd255, 1'b1, 1'b1, 1'b0, 9'd60,  1'b0});
        tbl.push_back('{1'b1, 8'd255, 1'b1, 1'b0, 1'b1, 9'd511, 1'b1});
        tbl.push_back('{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 9'd511, 1'b1});
        // Next block 1 x4: flag cleared.
        tbl.push_back('{1'b1, 8'd1,   1'b1, 1'b1, 1'b0, 9'd511, 1'b1});
        tbl.push_back('{1'b1, 8'd1,   1'b1, 1'b1, 1'b0, 9'd511, 1'b1});
        tbl.push_back('{1'b1, 8'd1,   1'b1, 1'b1, 1'b0, 9'd511, 1'b1});
        tbl.push_back('{1'b1, 8'd1,   1'b1, 1'b0, 1'b1, 9'd4,   1'b0});
        tbl.push_back('{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 9'd4,   1'b0});
        // 10,_,_,20,_,30,40: bubbles are not counted.
        tbl.push_back('{1'b1, 8'd10,  1'b1, 1'b1, 1'b0, 9'd4,   1'b0});
        tbl.push_back('{1'b0, 8'd99,  1'b1, 1'b1, 1'b0, 9'd4,   1'b0});
        tbl.push_back('{1'b0, 8'd99,  1'b1, 1'b1, 1'b0, 9'd4,   1'b0});
        tbl.push_back('{1'b1, 8'd20,  1'b1, 1'b1, 1'b0, 9'd4,   1'b0});
        tbl.push_back('{1'b0, 8'd99,  1'b1, 1'b1, 1'b0, 9'd4,   1'b0});
        tbl.push_back('{1'b1, 8'd30,  1'b1, 1'b1, 1'b0, 9'd4,   1'b0});
        tbl.push_back('{1'b1, 8'd40,  1'b1, 1'b0, 1'b1, 9'd100, 1'b0});
        tbl.push_back('{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 9'd100, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            tick();
            check_main($sformatf("tbl[%0d]", i), tbl[i].ir, tbl[i].ov, tbl[i].sum, tbl[i].ovf);
        end

        // Back-pressure: result held for 5 cycles while the producer offers 7.
        do_reset();
        feed4(8'd1, 8'd2, 8'd3, 8'd4);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'd7, 1'b0);
            tick();
            check_main($sformatf("stall[%0d]", k), 1'b0, 1'b1, 9'd10, 1'b0);
        end
        drive(1'b1, 8'd7, 1'b1);
        tick();
        check_main("stall_release", 1'b1, 1'b0, 9'd10, 1'b0);
        feed4(8'd7, 8'd2, 8'd2, 8'd2);
        check_main("stall_block2", 1'b0, 1'b1, 9'd13, 1'b0);

        // Reset mid-block discards the partial sum.
        drive(1'b0, 8'd0, 1'b1);
        tick();
        drive(1'b1, 8'd5, 1'b0);
        tick();
        drive(1'b1, 8'd6, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
        tick();
        rst = 1'b0;
        check_main("midrst", 1'b1, 1'b0, 9'd0, 1'b0);
        feed4(8'd1, 8'd2, 8'd3, 8'd4);
        check_main("midrst_block", 1'b0, 1'b1, 9'd10, 1'b0);

        // LEN=1 instance: each accept goes straight to DONE.
        iv1 = 1'b1; din1 = 8'd200; ordy1 = 1'b1;
        tick();
        check("len1_a.out_valid", 32'(ov1),   32'd1);
        check("len1_a.in_ready",  32'(ir1),   32'd0);
        check("len1_a.out_sum",   32'(osum1), 32'd200);
        check("len1_a.out_ovf",   32'(oovf1), 32'd0);
        din1 = 8'd100;
        tick();
        check("len1_h.out_valid", 32'(ov1),   32'd0);
        check("len1_h.in_ready",  32'(ir1),   32'd1);
        check("len1_h.out_sum",   32'(osum1), 32'd200);
        tick();
        check("len1_b.out_valid", 32'(ov1),   32'd1);
        check("len1_b.in_ready",  32'(ir1),   32'd0);
        check("len1_b.out_sum",   32'(osum1), 32'd100);
        iv1 = 1'b0;
        tick();
        check("len1_end.in_ready", 32'(ir1), 32'd1);

        // Randomized traffic against a block-level model: a block's result is
        // min(sum of its 4 accepted products, 511), overflow when it exceeds.
        do_reset();
        m_blk_sum = 0; m_blk_cnt = 0; m_pend = 1'b0;
        m_last_sum = 0; m_last_ovf = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            logic       r_v, r_o, r_r;
            logic [7:0] r_d;
            r_v = ($urandom_range(0, 3) != 0);
            r_d = 8'($urandom_range(0, 255));
            r_o = ($urandom_range(0, 2) != 0);
            r_r = ($urandom_range(0, 63) == 0);
            rst = r_r;
            drive(r_v, r_d, r_o);
            tick();
            if (r_r) begin
                m_blk_sum = 0; m_blk_cnt = 0; m_pend = 1'b0;
                m_last_sum = 0; m_last_ovf = 1'b0;
            end else if (m_pend) begin
                if (r_o) m_pend = 1'b0;
            end else if (r_v) begin
                m_blk_sum += int'(r_d);
                m_blk_cnt++;
                if (m_blk_cnt == 4) begin
                    m_pend     = 1'b1;
                    m_last_ovf = (m_blk_sum > MAX9);
                    m_last_sum = m_last_ovf ? MAX9 : m_blk_sum;
                    m_blk_sum  = 0;
                    m_blk_cnt  = 0;
                end
            end
            check_main($sformatf("rnd[%0d]", c), !m_pend, m_pend, 9'(m_last_sum), m_last_ovf);
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
